// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans all voices for each MIDI event, then
// retriggers, fills a free voice, or steals the oldest sounding voice.
module voice_allocator #(
    parameter int VOICES = 4,
    parameter int AGE_W  = 8
) (
    input  logic                  inCLK_50MHZ,
    input  logic                  inRESET,
    input  logic                  inEventValid,
    output logic                  outEventReady,
    input  logic                  inEventNoteOn,
    input  logic [6:0]            inEventNote,
    output logic [7*VOICES-1:0]   outVoiceNote,
    output logic [VOICES-1:0]     outVoiceActive,
    output logic [VOICES-1:0]     outVoiceLoad,
    output logic                  outStolen
);

    localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_APPLY = 2'd2;

    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [IW-1:0]    LAST    = IW'(VOICES - 1);

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [6:0]       lat_note;
    logic             lat_on;
    logic             hit_match;
    logic             hit_free;
    logic             hit_old;
    logic [IW-1:0]    match_idx;
    logic [IW-1:0]    free_idx;
    logic [IW-1:0]    old_idx;
    logic [AGE_W-1:0] old_age;
    logic [AGE_W-1:0] age [VOICES];

    logic [6:0]       cur_note;
    logic             cur_act;
    logic [AGE_W-1:0] cur_age;
    logic [IW-1:0]    tgt;
    logic             tgt_ok;

    assign outEventReady = (state == S_IDLE);

    always_comb begin
        cur_note = outVoiceNote[7*int'(idx) +: 7];
        cur_act  = outVoiceActive[idx];
        cur_age  = age[idx];
    end

    // Note-on priority: retrigger, then free voice, then steal the oldest.
    always_comb begin
        tgt    = old_idx;
        tgt_ok = 1'b0;
        if (lat_on) begin
            tgt_ok = 1'b1;
            if (hit_match)
                tgt = match_idx;
            else if (hit_free)
                tgt = free_idx;
        end else begin
            tgt    = match_idx;
            tgt_ok = hit_match;
        end
    end

    always_ff @(posedge inCLK_50MHZ or posedge inRESET) begin
        if (inRESET) begin
            state          <= S_IDLE;
            idx            <= '0;
            lat_note       <= '0;
            lat_on         <= 1'b0;
            hit_match      <= 1'b0;
            hit_free       <= 1'b0;
            hit_old        <= 1'b0;
            match_idx      <= '0;
            free_idx       <= '0;
            old_idx        <= '0;
            old_age        <= '0;
            outVoiceNote   <= '0;
            outVoiceActive <= '0;
            outVoiceLoad   <= '0;
            outStolen      <= 1'b0;
            for (int v = 0; v < VOICES; v++)
                age[v] <= '0;
        end else begin
            outVoiceLoad <= '0;
            outStolen    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (inEventValid) begin
                        lat_note  <= inEventNote;
                        lat_on    <= inEventNoteOn;
                        hit_match <= 1'b0;
                        hit_free  <= 1'b0;
                        hit_old   <= 1'b0;
                        idx       <= '0;
                        state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (cur_act && cur_note == lat_note) begin
                        hit_match <= 1'b1;
                        match_idx <= idx;
                    end
                    if (!cur_act && !hit_free) begin
                        hit_free <= 1'b1;
                        free_idx <= idx;
                    end
                    // Strict compare keeps the lower index on equal ages.
                    if (cur_act && (!hit_old || cur_age > old_age)) begin
                        hit_old <= 1'b1;
                        old_idx <= idx;
                        old_age <= cur_age;
                    end
                    if (idx == LAST)
                        state <= S_APPLY;
                    else
                        idx <= idx + 1'b1;
                end
                S_APPLY: begin
                    if (tgt_ok) begin
                        outVoiceLoad[tgt]   <= 1'b1;
                        outVoiceActive[tgt] <= lat_on;
                        if (lat_on) begin
                            outVoiceNote[7*int'(tgt) +: 7] <= lat_note;
                            outStolen <= !hit_match && !hit_free;
                            for (int v = 0; v < VOICES; v++) begin
                                if (IW'(v) == tgt)
                                    age[v] <= '0;
                                else if (outVoiceActive[v] && age[v] != AGE_MAX)
                                    age[v] <= age[v] + 1'b1;
                            end
                        end
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with VOICES=4.
module tb_voice_allocator;

    localparam int VOICES = 4;

    logic                clk;
    logic                rst;
    logic                ev_valid;
    logic                ev_ready;
    logic                ev_on;
    logic [6:0]          ev_note;
    logic [7*VOICES-1:0] v_note;
    logic [VOICES-1:0]   v_act;
    logic [VOICES-1:0]   v_load;
    logic                stolen;

    int checks = 0;
    int errors = 0;

    voice_allocator #(.VOICES(VOICES), .AGE_W(8)) dut (
        .inCLK_50MHZ   (clk),
        .inRESET       (rst),
        .inEventValid  (ev_valid),
        .outEventReady (ev_ready),
        .inEventNoteOn (ev_on),
        .inEventNote   (ev_note),
        .outVoiceNote  (v_note),
        .outVoiceActive(v_act),
        .outVoiceLoad  (v_load),
        .outStolen     (stolen)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [6:0] vn(input int v);
        return v_note[7*v +: 7];
    endfunction

    // Waits (bounded) for ready, then presents one event for exactly one edge.
    task automatic issue(input logic on, input logic [6:0] n);
        int k;
        k = 0;
        while (ev_ready !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (ev_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: ready=%b want 1", ev_ready);
        end
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = n;
        @(posedge clk); #1;
        ev_valid = 1'b0;
    endtask

    task automatic to_apply();
        repeat (VOICES + 1) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ev_valid = 1'b0;
        ev_on = 1'b0;
        ev_note = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({v_note, v_act, v_load, stolen} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {v_note, v_act, v_load, stolen});
        end
        checks++;
        if (ev_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", ev_ready);
        end
    endtask

    task automatic test_single();
        issue(1'b1, 7'd60);
        checks++;
        if (ev_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: got %b want 0", ev_ready);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (v_act !== 4'b0000 || v_load !== 4'b0000) begin
            errors++;
            $display("FAIL early_update: act=%b load=%b want 0000/0000", v_act, v_load);
        end
        @(posedge clk); #1;
        checks++;
        if (vn(0) !== 7'd60 || v_act !== 4'b0001 || v_load !== 4'b0001) begin
            errors++;
            $display("FAIL single_on: n0=%0d act=%b load=%b want 60/0001/0001", vn(0), v_act, v_load);
        end
        checks++;
        if (ev_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_return: got %b want 1", ev_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (v_load !== 4'b0000) begin
            errors++;
            $display("FAIL load_width: got %b want 0000", v_load);
        end
    endtask

    task automatic test_fill();
        logic [6:0] notes [4];
        notes = '{7'd60, 7'd62, 7'd64, 7'd67};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, notes[i]);
            to_apply();
            checks++;
            if (stolen !== 1'b0 || v_load !== 4'(1 << i)) begin
                errors++;
                $display("FAIL fill_%0d: stolen=%b load=%b want 0/%b", i, stolen, v_load, 4'(1 << i));
            end
        end
        checks++;
        if (vn(0) !== 7'd60 || vn(1) !== 7'd62 || vn(2) !== 7'd64 || vn(3) !== 7'd67 || v_act !== 4'b1111) begin
            errors++;
            $display("FAIL fill_state: %0d %0d %0d %0d act=%b want 60 62 64 67 1111",
                     vn(0), vn(1), vn(2), vn(3), v_act);
        end
    endtask

    task automatic test_steal();
        issue(1'b1, 7'd72);
        to_apply();
        checks++;
        if (vn(0) !== 7'd72 || v_load !== 4'b0001 || stolen !== 1'b1 || v_act !== 4'b1111) begin
            errors++;
            $display("FAIL steal: n0=%0d load=%b stolen=%b act=%b want 72/0001/1/1111",
                     vn(0), v_load, stolen, v_act);
        end
        @(posedge clk); #1;
        checks++;
        if (stolen !== 1'b0) begin
            errors++;
            $display("FAIL steal_pulse: got %b want 0", stolen);
        end
    endtask

    task automatic test_note_off();
        issue(1'b0, 7'd60);
        to_apply();
        checks++;
        if (v_load !== 4'b0000 || v_act !== 4'b1111 || vn(0) !== 7'd72) begin
            errors++;
            $display("FAIL off_nomatch: load=%b act=%b n0=%0d want 0000/1111/72", v_load, v_act, vn(0));
        end
        issue(1'b0, 7'd64);
        to_apply();
        checks++;
        if (v_act !== 4'b1011 || v_load !== 4'b0100 || vn(2) !== 7'd64) begin
            errors++;
            $display("FAIL off_match: act=%b load=%b n2=%0d want 1011/0100/64", v_act, v_load, vn(2));
        end
    endtask

    task automatic test_retrigger_hold();
        int pulses;
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'd62;
        @(posedge clk); #1;
        ev_note  = 7'd64;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (v_load != 4'b0000) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL hold_scan_load: pulses=%0d want 0", pulses);
        end
        @(posedge clk); #1;
        checks++;
        if (v_load !== 4'b0010 || vn(1) !== 7'd62 || v_act !== 4'b1011) begin
            errors++;
            $display("FAIL retrigger: load=%b n1=%0d act=%b want 0010/62/1011", v_load, vn(1), v_act);
        end
        @(posedge clk); #1;
        ev_valid = 1'b0;
        to_apply();
        checks++;
        if (v_load !== 4'b0100 || vn(2) !== 7'd64 || v_act !== 4'b1111) begin
            errors++;
            $display("FAIL held_event: load=%b n2=%0d act=%b want 0100/64/1111", v_load, vn(2), v_act);
        end
        // Ages now v0=2 v1=1 v2=0 v3=3: voice 3 is the oldest.
        issue(1'b1, 7'd70);
        to_apply();
        checks++;
        if (vn(3) !== 7'd70 || v_load !== 4'b1000 || stolen !== 1'b1) begin
            errors++;
            $display("FAIL age_steal: n3=%0d load=%b stolen=%b want 70/1000/1", vn(3), v_load, stolen);
        end
    endtask

    task automatic test_reset_midscan();
        issue(1'b1, 7'd65);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({v_note, v_act, v_load, stolen} !== '0) begin
            errors++;
            $display("FAIL midscan_reset: got %h want 0", {v_note, v_act, v_load, stolen});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (VOICES + 2) @(posedge clk);
        #1;
        checks++;
        if (ev_ready !== 1'b1 || v_act !== 4'b0000 || vn(0) === 7'd65 || vn(3) === 7'd65) begin
            errors++;
            $display("FAIL after_reset: ready=%b act=%b n0=%0d n3=%0d want 1/0000/not65",
                     ev_ready, v_act, vn(0), vn(3));
        end
        issue(1'b1, 7'd65);
        to_apply();
        checks++;
        if (vn(0) !== 7'd65 || v_load !== 4'b0001 || stolen !== 1'b0 || v_act !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_on: n0=%0d load=%b stolen=%b act=%b want 65/0001/0/0001",
                     vn(0), v_load, stolen, v_act);
        end
    endtask

    initial begin
        rst      = 1'b1;
        ev_valid = 1'b0;
        ev_on    = 1'b0;
        ev_note  = '0;
        test_reset();
        test_single();
        test_fill();
        test_steal();
        test_note_off();
        test_retrigger_hold();
        test_reset_midscan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
